// File: rtl/bist_pkg.sv
// Shared types and constants for the BIST sequencer and engine.
// Holds the sequencer state encoding and the engine field widths.
package bist_pkg;

  localparam int CFG_W    = 5;
  localparam int CHK_W    = 5;
  localparam int BSR_W    = CFG_W + CHK_W;
  localparam int STATUS_W = 16;

  localparam logic [3:0] STATUS_CLEAN    = 4'hF;
  localparam logic [3:0] STATUS_MISMATCH = 4'h5;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    UPD     = 3'd2,
    GAP     = 3'd3,
    SWITCH  = 3'd4,
    RUN     = 3'd5,
    SETTLE  = 3'd6,
    CAPTURE = 3'd7
  } bist_state_t;

  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v = value - 1;
    while (v > 0) begin
      res = res + 1;
      v = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/bist_run_timer.sv
// 16-bit saturating run counter with clear/enable and a fixed limit compare.
// Used for the sequencer run budget and for engine watchdogs.
module bist_run_timer #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        en,
  output logic [15:0] count,
  output logic        expired
);

  // Counter register; saturation is a safety net, the limit stops it first.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 16'd0;
    end else if (clear) begin
      count <= 16'd0;
    end else if (en && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end else begin
      count <= count;
    end
  end

  assign expired = (count == 16'(TIMEOUT));

endmodule

// File: rtl/bist_sequencer.sv
// Loads a test program into the BIST engine, runs it and captures the verdict.
// All outputs are registered from the next state, so they align with the state.
module bist_sequencer
  import bist_pkg::*;
#(
  parameter  int DEPTH   = 256,
  parameter  int TIMEOUT = 1024,
  parameter  int UPD_GAP = 2,
  localparam int WIDTH   = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                TLR,
  input  logic                start,
  input  logic [WIDTH:0]      len,
  input  logic                ent_valid,
  output logic                ent_ready,
  input  logic [BSR_W-1:0]    ent_data,
  output logic                busy,
  output logic                GETTEST_SELECT,
  output logic                UPDATEDR,
  output logic [BSR_W-1:0]    BSR,
  output logic                RUNBIST_SELECT,
  output logic                enable,
  input  logic                RESET_SM,
  input  logic                error,
  input  logic [STATUS_W-1:0] BIST_STATUS,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [STATUS_W-1:0] status,
  output logic [15:0]         run_cycles
);

  localparam int LEN_W = WIDTH + 1;

  bist_state_t      state;
  bist_state_t      next_state;
  logic [LEN_W-1:0] remaining;
  logic [LEN_W-1:0] len_clamped;
  logic [15:0]      gap_cnt;
  logic [15:0]      run_count;
  logic             run_expired;
  logic             run_en;
  logic             start_acc;
  logic             accept;
  logic             run_abort;
  logic             first_run;

  assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;
  assign start_acc   = (state == IDLE) && start;
  assign run_en      = (next_state == RUN);
  // The engine may still show a stale stop pulse on the first run cycle.
  assign first_run   = (run_count == 16'd1);

  bist_run_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_run_timer (
    .clk     (clk),
    .rst     (TLR),
    .clear   (start_acc),
    .en      (run_en),
    .count   (run_count),
    .expired (run_expired)
  );

  // Next-state logic.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    run_abort  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = (len == {LEN_W{1'b0}}) ? SWITCH : LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: begin
        if (ent_valid && ent_ready) begin
          accept     = 1'b1;
          next_state = UPD;
        end else begin
          next_state = LOAD;
        end
      end
      UPD: next_state = GAP;
      GAP: begin
        if (gap_cnt == 16'd0) begin
          next_state = (remaining != {LEN_W{1'b0}}) ? LOAD : SWITCH;
        end else begin
          next_state = GAP;
        end
      end
      SWITCH: next_state = RUN;
      RUN: begin
        // An engine stop beats a simultaneous timeout.
        if (RESET_SM && !first_run) begin
          next_state = SETTLE;
        end else if (run_expired) begin
          run_abort  = 1'b1;
          next_state = SETTLE;
        end else begin
          next_state = RUN;
        end
      end
      SETTLE:  next_state = CAPTURE;
      CAPTURE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register and control outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (TLR) begin
      state          <= IDLE;
      busy           <= 1'b0;
      ent_ready      <= 1'b0;
      GETTEST_SELECT <= 1'b0;
      UPDATEDR       <= 1'b0;
      RUNBIST_SELECT <= 1'b0;
      enable         <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= next_state;
      busy           <= (next_state != IDLE);
      ent_ready      <= (next_state == LOAD);
      GETTEST_SELECT <= (next_state inside {LOAD, UPD, GAP});
      UPDATEDR       <= (next_state == UPD);
      RUNBIST_SELECT <= (next_state inside {RUN, SETTLE, CAPTURE});
      enable         <= (next_state == RUN);
      done           <= (next_state == CAPTURE);
    end
  end

  // Load datapath: BSR holding register, remaining entries and gap timer.
  always_ff @(posedge clk) begin
    if (TLR) begin
      BSR       <= {BSR_W{1'b0}};
      remaining <= {LEN_W{1'b0}};
      gap_cnt   <= 16'd0;
    end else begin
      if (accept) begin
        BSR <= ent_data;
      end else begin
        BSR <= BSR;
      end
      if (start_acc) begin
        remaining <= len_clamped;
      end else if (state == UPD) begin
        remaining <= remaining - LEN_W'(1);
      end else begin
        remaining <= remaining;
      end
      if (state == UPD) begin
        gap_cnt <= 16'(UPD_GAP - 1);
      end else if ((state == GAP) && (gap_cnt != 16'd0)) begin
        gap_cnt <= gap_cnt - 16'd1;
      end else begin
        gap_cnt <= gap_cnt;
      end
    end
  end

  // Result registers, cleared by an accepted start and latched in CAPTURE.
  always_ff @(posedge clk) begin
    if (TLR) begin
      pass       <= 1'b0;
      timeout    <= 1'b0;
      status     <= {STATUS_W{1'b0}};
      run_cycles <= 16'd0;
    end else if (start_acc) begin
      pass       <= 1'b0;
      timeout    <= 1'b0;
      status     <= {STATUS_W{1'b0}};
      run_cycles <= 16'd0;
    end else begin
      timeout <= timeout | run_abort;
      if (state == CAPTURE) begin
        status     <= BIST_STATUS;
        run_cycles <= run_count;
        pass       <= !error && !timeout;
      end else begin
        status     <= status;
        run_cycles <= run_cycles;
        pass       <= pass;
      end
    end
  end

endmodule

// File: tb/tb_bist_sequencer.sv
// Directed bench for bist_sequencer with a hand-driven engine model.
module tb_bist_sequencer;
  import bist_pkg::*;

  localparam int DEPTH   = 256;
  localparam int TIMEOUT = 16;
  localparam int UPD_GAP = 2;

  logic        clk = 1'b0;
  logic        TLR;
  logic        start;
  logic [8:0]  len;
  logic        ent_valid;
  logic        ent_ready;
  logic [9:0]  ent_data;
  logic        busy;
  logic        GETTEST_SELECT;
  logic        UPDATEDR;
  logic [9:0]  BSR;
  logic        RUNBIST_SELECT;
  logic        enable;
  logic        RESET_SM;
  logic        error;
  logic [15:0] BIST_STATUS;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] status;
  logic [15:0] run_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gts_cnt  = 0;
  int upd_cyc[$];
  logic [9:0] upd_bsr[$];
  logic [9:0] ents [8];

  bist_sequencer #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .UPD_GAP (UPD_GAP)
  ) dut (
    .clk            (clk),
    .TLR            (TLR),
    .start          (start),
    .len            (len),
    .ent_valid      (ent_valid),
    .ent_ready      (ent_ready),
    .ent_data       (ent_data),
    .busy           (busy),
    .GETTEST_SELECT (GETTEST_SELECT),
    .UPDATEDR       (UPDATEDR),
    .BSR            (BSR),
    .RUNBIST_SELECT (RUNBIST_SELECT),
    .enable         (enable),
    .RESET_SM       (RESET_SM),
    .error          (error),
    .BIST_STATUS    (BIST_STATUS),
    .done           (done),
    .pass           (pass),
    .timeout        (timeout),
    .status         (status),
    .run_cycles     (run_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every UPDATEDR pulse and all GETTEST_SELECT activity.
  always @(negedge clk) begin
    if (UPDATEDR) begin
      upd_cyc.push_back(cyc);
      upd_bsr.push_back(BSR);
    end
    if (GETTEST_SELECT) gts_cnt <= gts_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [49:0] outs();
    return {busy, GETTEST_SELECT, UPDATEDR, ent_ready, BSR, RUNBIST_SELECT, enable,
            done, pass, timeout, status, run_cycles[14:0]};
  endfunction

  function automatic logic [33:0] results();
    return {pass, timeout, status, run_cycles};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_prog(input logic [8:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
    len   = 9'd0;
  endtask

  // Stream entries with ent_valid held high until the run phase begins.
  task automatic feed_until_run(input int n, input string tag);
    int idx;
    int guard;
    logic rdy;
    idx = 0;
    guard = 0;
    ent_valid = 1'b1;
    ent_data = ents[0];
    while (!enable && guard < 3000) begin
      rdy = ent_ready;
      tick();
      guard++;
      if (rdy) begin
        idx++;
        ent_data = ents[idx % 8];
      end
    end
    check_eq({tag, "_reached_run"}, 64'(enable), 64'd1);
    check_eq({tag, "_accepted"}, 64'(idx), 64'(n));
  endtask

  // Engine model: stop pulse on run cycle stop_at (0 = never).
  task automatic run_to_done(input int stop_at, input bit pulse_first, input bit poke_run,
                             input bit poke_done, output int ncyc, output int lat);
    int k;
    k = 1;
    while (enable && k < 200) begin
      RESET_SM = (k == stop_at) || (pulse_first && k == 1);
      if (poke_run && k == 2) begin
        start = 1'b1;
        len   = 9'd3;
      end
      tick();
      RESET_SM = 1'b0;
      start    = 1'b0;
      len      = 9'd0;
      if (enable) k++;
    end
    ncyc = k;
    lat = 1;
    while (!done && lat < 10) begin
      tick();
      lat++;
    end
    if (poke_done) begin
      start = 1'b1;
      len   = 9'd0;
    end
    tick();
    start = 1'b0;
    ent_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ncyc;
    int lat;
    int base;
    int gbase;
    int pulses;
    int idx;
    int guard;
    logic rdy;

    TLR = 1'b1;
    start = 1'b0;
    len = 9'd0;
    ent_valid = 1'b0;
    ent_data = 10'd0;
    RESET_SM = 1'b0;
    error = 1'b0;
    BIST_STATUS = 16'd0;
    ents = '{10'h3E1, 10'h155, 10'h2A0, 10'h0F0, 10'h30C, 10'h001, 10'h3FF, 10'h2D2};
    repeat (3) tick();
    check_eq("reset_outputs", 64'(outs()), 64'd0);
    TLR = 1'b0;
    tick();
    check_eq("idle_outputs", 64'(outs()), 64'd0);

    // Three entries, then an engine stop on run cycle 12.
    BIST_STATUS = 16'h12AF;
    base = upd_cyc.size();
    start_prog(9'd3);
    check_eq("start_busy", 64'({busy, GETTEST_SELECT, ent_ready}), 64'h7);
    feed_until_run(3, "t1");
    run_to_done(12, 1'b0, 1'b0, 1'b0, ncyc, lat);
    check_eq("t1_run_len", 64'(ncyc), 64'd12);
    check_eq("t1_done_lat", 64'(lat), 64'd2);
    check_eq("t1_busy_off", 64'({busy, done}), 64'd0);
    check_eq("t1_results", 64'(results()), 64'({1'b1, 1'b0, 16'h12AF, 16'd12}));
    check_eq("t1_upd_count", 64'(upd_cyc.size() - base), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (base + i < upd_cyc.size()) begin
        check_eq($sformatf("t1_bsr%0d", i), 64'(upd_bsr[base + i]), 64'(ents[i]));
        if (i > 0) check_eq($sformatf("t1_gap%0d", i),
                            64'(upd_cyc[base + i] - upd_cyc[base + i - 1]), 64'(UPD_GAP + 2));
      end
    end

    // Empty program with an early stale stop pulse and an engine error.
    error = 1'b1;
    BIST_STATUS = 16'h0035;
    gbase = gts_cnt;
    start_prog(9'd0);
    check_eq("t3_switch", 64'({busy, GETTEST_SELECT, RUNBIST_SELECT, enable}), 64'h8);
    check_eq("t3_cleared", 64'(results()), 64'd0);
    feed_until_run(0, "t3");
    run_to_done(3, 1'b1, 1'b0, 1'b0, ncyc, lat);
    check_eq("t3_run_len", 64'(ncyc), 64'd3);
    check_eq("t3_results", 64'(results()), 64'({1'b0, 1'b0, 16'h0035, 16'd3}));
    check_eq("t3_no_gts", 64'(gts_cnt - gbase), 64'd0);

    // Timeout with no stop pulse.
    error = 1'b0;
    BIST_STATUS = 16'h000F;
    start_prog(9'd0);
    feed_until_run(0, "t4");
    run_to_done(0, 1'b0, 1'b0, 1'b0, ncyc, lat);
    check_eq("t4_run_len", 64'(ncyc), 64'(TIMEOUT));
    check_eq("t4_done_lat", 64'(lat), 64'd2);
    check_eq("t4_results", 64'(results()), 64'({1'b0, 1'b1, 16'h000F, 16'd16}));

    // Stop pulse on the timeout cycle: the stop wins.
    BIST_STATUS = 16'h7A5F;
    start_prog(9'd0);
    feed_until_run(0, "t5");
    run_to_done(TIMEOUT, 1'b0, 1'b0, 1'b0, ncyc, lat);
    check_eq("t5_results", 64'(results()), 64'({1'b1, 1'b0, 16'h7A5F, 16'd16}));

    // Reset in the gap after entry 2, then reload from entry 0.
    start_prog(9'd3);
    pulses = 0;
    idx = 0;
    guard = 0;
    ent_valid = 1'b1;
    ent_data = ents[0];
    while (pulses < 2 && guard < 100) begin
      rdy = ent_ready;
      tick();
      guard++;
      if (rdy) begin
        idx++;
        ent_data = ents[idx % 8];
      end
      if (UPDATEDR) pulses++;
    end
    tick();
    check_eq("t6_in_gap", 64'({GETTEST_SELECT, ent_ready, UPDATEDR}), 64'h4);
    TLR = 1'b1;
    tick();
    check_eq("t6_tlr_outputs", 64'(outs()), 64'd0);
    TLR = 1'b0;
    ent_valid = 1'b0;
    tick();
    check_eq("t6_after_tlr", 64'(outs()), 64'd0);
    base = upd_cyc.size();
    BIST_STATUS = 16'hA5AF;
    start_prog(9'd2);
    feed_until_run(2, "t6");
    run_to_done(5, 1'b0, 1'b1, 1'b1, ncyc, lat);
    check_eq("t6_run_len", 64'(ncyc), 64'd5);
    check_eq("t6_results", 64'(results()), 64'({1'b1, 1'b0, 16'hA5AF, 16'd5}));
    check_eq("t6_upd_count", 64'(upd_cyc.size() - base), 64'd2);
    if (upd_cyc.size() - base == 2) begin
      check_eq("t6_bsr0", 64'(upd_bsr[base]), 64'(ents[0]));
      check_eq("t6_bsr1", 64'(upd_bsr[base + 1]), 64'(ents[1]));
    end
    repeat (2) tick();
    check_eq("t6_start_ignored", 64'({busy, GETTEST_SELECT, RUNBIST_SELECT}), 64'd0);
    check_eq("t6_results_held", 64'(results()), 64'({1'b1, 1'b0, 16'hA5AF, 16'd5}));

    // Oversized length is clamped to DEPTH entries.
    base = upd_cyc.size();
    BIST_STATUS = 16'h00FF;
    start_prog(9'h1FF);
    feed_until_run(DEPTH, "t7");
    run_to_done(2, 1'b0, 1'b0, 1'b0, ncyc, lat);
    check_eq("t7_upd_count", 64'(upd_cyc.size() - base), 64'(DEPTH));
    check_eq("t7_results", 64'(results()), 64'({1'b1, 1'b0, 16'h00FF, 16'd2}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
